// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded integer register file.
package regfile_sb_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    // Architectural zero register index: no storage, no pending bit.
    localparam int unsigned REG_ZERO      = 0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared at writeback or flush, looked up combinationally for both read ports.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_rd,
    input  logic          w_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Next-state: flush beats issue, issue beats writeback (younger producer wins).
    always_comb begin
        pending_d = pending_q;
        if (!flush) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (issue_en && issue_rd == AW'(i)) begin
                    pending_d[i] = 1'b1;
                end else if (w_en && rd_addr == AW'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end else begin
            pending_d = '0;
        end
        pending_d[REG_ZERO] = 1'b0;
    end

    // Pending vector, cleared asynchronously so a reset discards in-flight issues.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Busy lookup; a same-cycle writeback to the register hides its pending bit.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1_addr != AW'(REG_ZERO)) begin
            if (BYPASS && w_en && rd_addr == rs1_addr) begin
                rs1_busy = 1'b0;
            end else begin
                rs1_busy = pending_q[rs1_addr];
            end
        end
        if (rs2_addr != AW'(REG_ZERO)) begin
            if (BYPASS && w_en && rd_addr == rs2_addr) begin
                rs2_busy = 1'b0;
            end else begin
                rs2_busy = pending_q[rs2_addr];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with x0 hardwired to zero, two combinational read ports,
// one write port, optional write-to-read bypass and a RAW-hazard scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEFAULT,
    parameter int unsigned NREGS  = NREGS_DEFAULT,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic            w_en,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_valid;
    logic            fwd_ok;

    assign wr_valid = w_en && (rd_addr != AW'(REG_ZERO));
    // Forwarding is suppressed during reset so every output reads 0 then.
    assign fwd_ok   = BYPASS && reset_n && w_en;

    // Register storage; entry 0 is never written and stays at its reset value of 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_valid) begin
            regs_q[rd_addr] <= w_data;
        end
    end

    // Read mux: x0 first, then same-cycle forwarding, then stored value.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != AW'(REG_ZERO)) begin
            if (fwd_ok && rd_addr == rs1_addr) begin
                rs1_data = w_data;
            end else begin
                rs1_data = regs_q[rs1_addr];
            end
        end
        if (rs2_addr != AW'(REG_ZERO)) begin
            if (fwd_ok && rd_addr == rs2_addr) begin
                rs2_data = w_data;
            end else begin
                rs2_data = regs_q[rs2_addr];
            end
        end
    end

    regfile_sb_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .w_en     (w_en),
        .rd_addr  (rd_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass and non-bypass instances share stimulus,
// a 64-bit/16-entry instance covers the parameter sweep, and a short pseudo-random
// phase compares against a reference model.
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, issue_rd;
    logic [31:0] w_data;
    logic        w_en, issue_en, flush;

    logic [31:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;

    logic [3:0]  c_rs1_addr, c_rs2_addr, c_rd_addr, c_issue_rd;
    logic [63:0] c_w_data, c_rs1_data, c_rs2_data;
    logic        c_w_en, c_issue_en, c_flush, c_rs1_busy, c_rs2_busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;

    always #5 clock = ~clock;

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_dut_a (
        .clock(clock), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .rd_addr(rd_addr), .w_data(w_data), .w_en(w_en),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_dut_b (
        .clock(clock), .reset_n(reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rd_addr(rd_addr), .w_data(w_data), .w_en(w_en),
        .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .BYPASS(1'b1)) u_dut_c (
        .clock(clock), .reset_n(reset_n),
        .rs1_addr(c_rs1_addr), .rs2_addr(c_rs2_addr),
        .rs1_data(c_rs1_data), .rs2_data(c_rs2_data),
        .rd_addr(c_rd_addr), .w_data(c_w_data), .w_en(c_w_en),
        .issue_en(c_issue_en), .issue_rd(c_issue_rd), .flush(c_flush),
        .rs1_busy(c_rs1_busy), .rs2_busy(c_rs2_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && w_en && rd_addr == a) return w_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 1'b0;
        if (byp && w_en && rd_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    initial begin
        reset_n  = 1'b0;
        rs1_addr = 5'd5;  rs2_addr = 5'd5;  rd_addr = 5'd5;  w_data = 32'h1;
        w_en     = 1'b1;  issue_en = 1'b0;  issue_rd = 5'd0; flush = 1'b0;
        c_rs1_addr = 4'd0; c_rs2_addr = 4'd0; c_rd_addr = 4'd0; c_issue_rd = 4'd0;
        c_w_data = 64'd0; c_w_en = 1'b0; c_issue_en = 1'b0; c_flush = 1'b0;

        // Reset held: bypass must not leak w_data to the outputs.
        repeat (2) tick();
        check("rst_a_rs1_data", 64'(a_rs1_data), 64'd0);
        check("rst_b_rs1_data", 64'(b_rs1_data), 64'd0);
        check("rst_a_rs1_busy", 64'(a_rs1_busy), 64'd0);
        w_en = 1'b0;
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check("post_rst_data", {a_rs1_data, a_rs2_data}, 64'd0);
            check("post_rst_busy", {62'd0, a_rs1_busy, a_rs2_busy}, 64'd0);
        end

        // Write r5 with same-cycle read: bypass sees it now, plain file after the edge.
        tick();
        w_en = 1'b1; rd_addr = 5'd5; w_data = 32'hDEAD_BEEF; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        check("wr_byp_pre", 64'(a_rs1_data), 64'hDEAD_BEEF);
        check("wr_nobyp_pre", 64'(b_rs1_data), 64'd0);
        tick();
        w_en = 1'b0;
        #1;
        check("wr_byp_post", 64'(a_rs1_data), 64'hDEAD_BEEF);
        check("wr_nobyp_post", 64'(b_rs1_data), 64'hDEAD_BEEF);
        check("wr_rs2_same", 64'(a_rs2_data), 64'hDEAD_BEEF);
        check("wr_nonpend_busy", 64'(a_rs1_busy), 64'd0);

        // x0 writes are dropped and never forwarded.
        w_en = 1'b1; rd_addr = 5'd0; w_data = 32'hFFFF_FFFF; rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        check("x0_pre", {a_rs1_data, a_rs2_data}, 64'd0);
        tick();
        w_en = 1'b0; issue_en = 1'b1; issue_rd = 5'd0;
        #1;
        check("x0_post", {a_rs1_data, a_rs2_data}, 64'd0);
        tick();
        issue_en = 1'b0;
        #1;
        check("x0_busy", 64'(a_rs1_busy), 64'd0);

        // Scoreboard: issue r7 at t0, busy from t1, writeback at t3 clears it.
        rs2_addr = 5'd7; issue_en = 1'b1; issue_rd = 5'd7;
        #1;
        check("sb_t0", 64'(a_rs2_busy), 64'd0);
        tick();
        issue_en = 1'b0;
        #1;
        check("sb_t1", 64'(a_rs2_busy), 64'd1);
        tick();
        check("sb_t2", 64'(a_rs2_busy), 64'd1);
        tick();
        w_en = 1'b1; rd_addr = 5'd7; w_data = 32'h0000_0077;
        #1;
        check("sb_t3_byp", 64'(a_rs2_busy), 64'd0);
        check("sb_t3_nobyp", 64'(b_rs2_busy), 64'd1);
        tick();
        w_en = 1'b0;
        #1;
        check("sb_t4_busy", {62'd0, a_rs2_busy, b_rs2_busy}, 64'd0);
        check("sb_t4_data", 64'(a_rs2_data), 64'h77);

        // Issue and writeback to pending r9 in one cycle: data lands, bit stays set.
        issue_en = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9;
        tick();
        issue_en = 1'b0;
        #1;
        check("sim_pend", 64'(a_rs1_busy), 64'd1);
        issue_en = 1'b1; issue_rd = 5'd9; w_en = 1'b1; rd_addr = 5'd9; w_data = 32'h0000_0099;
        #1;
        check("sim_pre_busy", 64'(a_rs1_busy), 64'd0);
        tick();
        issue_en = 1'b0; w_en = 1'b0;
        #1;
        check("sim_post_busy", 64'(a_rs1_busy), 64'd1);
        check("sim_post_data", 64'(a_rs1_data), 64'h99);

        // Flush clears everything and ignores the same-cycle issue to r12.
        flush = 1'b1; issue_en = 1'b1; issue_rd = 5'd12; rs2_addr = 5'd12;
        tick();
        flush = 1'b0; issue_en = 1'b0;
        #1;
        check("flush_r9", 64'(a_rs1_busy), 64'd0);
        check("flush_r12", 64'(a_rs2_busy), 64'd0);

        // Asynchronous reset mid-cycle with a write and an issue in flight.
        issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        issue_en = 1'b0; w_en = 1'b1; rd_addr = 5'd3; w_data = 32'h0000_1234;
        tick();
        w_en = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        check("mid_data", 64'(a_rs1_data), 64'h1234);
        check("mid_busy", 64'(a_rs2_busy), 64'd1);
        w_en = 1'b1; rd_addr = 5'd3; w_data = 32'h0000_5555; issue_en = 1'b1; issue_rd = 5'd6;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_data", {a_rs1_data, a_rs2_data}, 64'd0);
        check("arst_busy", {62'd0, a_rs1_busy, a_rs2_busy}, 64'd0);
        tick();
        w_en = 1'b0; issue_en = 1'b0; rs2_addr = 5'd6;
        #3;
        reset_n = 1'b1;
        #1;
        check("arst_drop_wr", 64'(a_rs1_data), 64'd0);
        check("arst_drop_iss", 64'(a_rs2_busy), 64'd0);

        // Parameter sweep instance: 64-bit data in the top register of a 16-entry file.
        tick();
        c_w_en = 1'b1; c_rd_addr = 4'd15; c_w_data = 64'h0123_4567_89AB_CDEF;
        c_rs1_addr = 4'd15; c_rs2_addr = 4'd0;
        tick();
        c_w_en = 1'b0;
        #1;
        check("c_r15", c_rs1_data, 64'h0123_4567_89AB_CDEF);
        check("c_r0", c_rs2_data, 64'd0);

        // Pseudo-random traffic on a small address window against a reference model.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = 32'd0;
        for (int k = 0; k < 300; k++) begin
            tick();
            rs1_addr = 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            rd_addr  = 5'($urandom_range(0, 7));
            issue_rd = 5'($urandom_range(0, 7));
            w_data   = $urandom;
            w_en     = ($urandom_range(0, 1) == 1);
            issue_en = ($urandom_range(0, 1) == 1);
            flush    = ($urandom_range(0, 15) == 0);
            #1;
            check("rnd_a_rs1", 64'(a_rs1_data), 64'(exp_data(rs1_addr, 1'b1)));
            check("rnd_a_rs2", 64'(a_rs2_data), 64'(exp_data(rs2_addr, 1'b1)));
            check("rnd_a_busy", {62'd0, a_rs1_busy, a_rs2_busy},
                  {62'd0, exp_busy(rs1_addr, 1'b1), exp_busy(rs2_addr, 1'b1)});
            check("rnd_b_rs1", 64'(b_rs1_data), 64'(exp_data(rs1_addr, 1'b0)));
            check("rnd_b_busy", {62'd0, b_rs1_busy, b_rs2_busy},
                  {62'd0, exp_busy(rs1_addr, 1'b0), exp_busy(rs2_addr, 1'b0)});
            @(posedge clock);
            if (w_en && rd_addr != 5'd0) m_regs[rd_addr] = w_data;
            if (flush) begin
                m_pend = 32'd0;
            end else begin
                if (w_en && rd_addr != 5'd0) m_pend[rd_addr] = 1'b0;
                if (issue_en && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's integer register file.
- Provides two combinational read ports and one synchronous write port, with register 0 hardwired to zero.
- Adds optional write-to-read bypass, so writeback data is visible in the same cycle.
- Adds a per-register pending-write scoreboard, so decode can detect RAW hazards and stall.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding and busy-clear; 0 = plain register file.
- AW (localparam), $clog2(NREGS), address width.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- rd_addr  in  AW  writeback destination.
- w_data  in  XLEN  writeback data.
- w_en  in  1  writeback enable.
- issue_en  in  1  an instruction writing issue_rd leaves decode this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- flush  in  1  clear all pending bits (pipeline squash).
- rs1_busy  out  1  rs1_addr has an outstanding write.
- rs2_busy  out  1  rs2_addr has an outstanding write.

Behaviour:
- Storage: regs[1..NREGS-1] of XLEN bits, plus pending[1..NREGS-1] bits. Index 0 has no storage and no pending bit.
- Reset: reset_n low asynchronously clears all regs and all pending bits. While reset_n is low, every output is 0.
- Reset is honoured mid-operation: an assertion in the same cycle as a write or issue discards that write or issue.
- Write: at posedge, if w_en and rd_addr != 0, then regs[rd_addr] <= w_data. Otherwise no register changes. A write to x0 is silently dropped.
- Read: rsN_data = 0 if rsN_addr == 0.
- Read with bypass: else, if BYPASS and w_en and rd_addr == rsN_addr, rsN_data = w_data.
- Read otherwise: rsN_data = regs[rsN_addr].
- Read latency: 0 cycles with bypass; 1 cycle (visible after the edge) without.
- Scoreboard next-state, per register i != 0, in priority order:
  - flush: pending[i] <= 0. Issue is ignored in the same cycle.
  - else issue_en and issue_rd == i: pending[i] <= 1. Issue wins over a same-cycle writeback to the same register, because the new producer is the younger one.
  - else w_en and rd_addr == i: pending[i] <= 0.
  - else: hold.
- issue_rd == 0 never sets a pending bit.
- Busy: rsN_busy = 0 if rsN_addr == 0.
- Busy with bypass: else, if BYPASS and w_en and rd_addr == rsN_addr, rsN_busy = 0.
- Busy otherwise: rsN_busy = pending[rsN_addr].
- Busy is purely combinational from current state and inputs. Issue in cycle t affects busy only from cycle t+1.
- Writeback to a non-pending register: the data is written, and pending stays 0. This is legal, not an error.
- Issue to an already-pending register: the bit stays 1. There is no counter; a single outstanding producer per register is assumed.
- rs1_addr == rs2_addr: both ports return identical data and busy.

Decomposition:
- Shared package holds XLEN_DEFAULT = 32, NREGS_DEFAULT = 32, and the REG_ZERO = 0 constant.
- Sub-module regfile_sb_scoreboard holds the pending vector, the flush/issue/clear update and the busy lookup.
- The top level keeps the storage and read mux, and instantiates one scoreboard.

Test Plan:
- Reset: hold reset_n = 0, then release; read all 32 addresses -> data 0 and busy 0. Assert reset_n asynchronously mid-cycle after a write -> outputs drop to 0 immediately.
- Write/read, BYPASS = 1: w_en = 1, rd = 5, w_data = 32'hDEAD_BEEF, rs1 = 5 in the same cycle -> rs1_data = DEAD_BEEF before the edge and after it. With BYPASS = 0 -> old value (0) before the edge, DEAD_BEEF after.
- x0: write rd = 0, w_data = 32'hFFFF_FFFF; then rs1 = rs2 = 0 -> both 0. issue_rd = 0 -> rs1_busy stays 0.
- Scoreboard: issue rd = 7 at t0 -> rs2_busy (rs2 = 7) is 1 from t1. Writeback rd = 7 at t3 -> busy 0 in t3 (bypass) and in t4.
- Simultaneous: pending[9] = 1, then in one cycle issue_rd = 9 and w_en rd = 9 -> regs[9] is updated and pending[9] stays 1. Next, flush with issue_rd = 12 -> all pending 0, including 12.
- Parameter sweep: XLEN = 64, NREGS = 16 -> write 64'h0123_4567_89AB_CDEF to r15 and read it back. Random issue/writeback/flush sequences are checked against a reference model.
